clz_expand: RTL and testbench

Multi-cycle inverse of the CLZ unit in the 54-instruction MIPS CPU. It accepts a leading-zero count and returns two 32-bit words:
- the smallest word with exactly that many leading zeros;
- the largest word with exactly that many leading zeros.

The result is built bit-serially, one bit per cycle, MSB first. It sits beside the multi-cycle DIV/MULT units and uses the same start/busy handshake, so the controller stalls on `busy` in the same way.

---
 rtl/clz_expand.sv | 111 +++++++++++
 tb/tb_clz_expand.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clz_expand.sv
// clz_expand: bit-serial inverse of a count-leading-zeros unit.
// Given a leading-zero count n, builds (MSB first, one bit per cycle) the
// smallest and the largest WIDTH-bit words having exactly n leading zeros.
//
// Handshake: a request is accepted when start=1 while busy=0 and the FSM is
// in IDLE; count is captured on that edge. busy stays high while bits are
// being shifted, done pulses for one cycle once min_out/max_out/err are
// valid, and the results hold until the next accepted request. start is
// ignored while busy or during the done cycle; nothing is queued.
module clz_expand #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out,
  output logic             err
);

  localparam int KB = $clog2(WIDTH);      // bit index width
  localparam int NB = $clog2(WIDTH + 1);  // captured count width (0..WIDTH)
  localparam int SW = KB + 2;             // signed compare width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [KB-1:0] k;
  logic [NB-1:0] n;

  logic                 count_bad;
  logic signed [SW-1:0] k_s;
  logic signed [SW-1:0] thr;
  logic                 min_bit;
  logic                 max_bit;

  // Out-of-range counts skip the shift phase entirely.
  assign count_bad = (count > 32'(WIDTH));

  // Position of the single leading one; goes to -1 when n == WIDTH so that
  // neither register receives any one bit.
  assign k_s     = $signed({2'b00, k});
  assign thr     = $signed(SW'(WIDTH - 1)) - $signed(SW'(n));
  assign min_bit = (k_s == thr);
  assign max_bit = (k_s <= thr);

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = count_bad ? DONE : RUN;
        end
      end
      RUN: begin
        if (k == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered status flags and the two shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      min_out <= '0;
      max_out <= '0;
      k       <= '0;
      n       <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            n       <= count[NB-1:0];
            k       <= KB'(WIDTH - 1);
            min_out <= '0;
            max_out <= '0;
            err     <= count_bad;
          end
        end
        RUN: begin
          min_out <= {min_out[WIDTH-2:0], min_bit};
          max_out <= {max_out[WIDTH-2:0], max_bit};
          k       <= k - KB'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clz_expand.sv
// Testbench for clz_expand: directed cases plus randomized counts, checked
// against a value model derived from the leading-zero definition.
module tb_clz_expand;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  count;
  logic         busy;
  logic         done;
  logic [W-1:0] min_out;
  logic [W-1:0] max_out;
  logic         err;

  int tests_run;
  int tests_failed;

  clz_expand #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .min_out (min_out),
    .max_out (max_out),
    .err     (err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: leading zeros of a word, counted bit by bit from the top.
  function automatic int clz(input logic [W-1:0] v);
    int z = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return z;
      z++;
    end
    return z;
  endfunction

  // Reference: smallest word with n leading zeros is a lone one at bit W-1-n.
  function automatic logic [W-1:0] ref_min(input logic [31:0] n);
    logic [W-1:0] one = 1;
    if (n >= W) return '0;
    return one << (W - 1 - n);
  endfunction

  // Reference: largest word with n leading zeros is all ones below that point.
  function automatic logic [W-1:0] ref_max(input logic [31:0] n);
    logic [W-1:0] ones = '1;
    if (n >= W) return '0;
    return ones >> n;
  endfunction

  // Driver: issue one request, follow it to done, then check everything.
  // With poke set, extra start pulses are thrown in at cycles 3 and 20.
  task automatic run_op(input logic [31:0] cnt, input bit poke);
    bit valid;
    int cyc;
    int done_cnt;
    valid = (cnt <= W);
    @(negedge clk);
    start = 1'b1;
    count = cnt;
    @(negedge clk);
    start = 1'b0;
    count = $urandom;
    check("busy_after_start", {31'd0, busy}, {31'd0, valid});
    cyc = 0;
    while (!done && cyc < 100) begin
      if (valid) check("busy_in_run", {31'd0, busy}, 32'd1);
      start = poke && (cyc == 3 || cyc == 20);
      count = $urandom_range(0, W);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", cyc, valid ? W : 0);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("min_out", min_out, valid ? ref_min(cnt) : '0);
    check("max_out", max_out, valid ? ref_max(cnt) : '0);
    check("err", {31'd0, err}, {31'd0, !valid});
    if (valid) begin
      check("clz_min", clz(min_out), cnt);
      check("clz_max", clz(max_out), cnt);
    end
    // done must be a single pulse and results must hold afterwards
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("done_single", done_cnt, 0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("min_hold", min_out, valid ? ref_min(cnt) : '0);
    check("max_hold", max_out, valid ? ref_max(cnt) : '0);
  endtask

  initial begin
    int done_seen;
    logic [31:0] c;
    tests_run    = 0;
    tests_failed = 0;
    start = 1'b0;
    count = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_min", min_out, '0);
    check("rst_max", max_out, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a run aborts it without a done pulse
    start = 1'b1;
    count = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_min", min_out, '0);
    check("abort_max", max_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op(32'd5, 1'b0);

    // Directed boundaries
    run_op(32'd0, 1'b0);
    run_op(32'd31, 1'b0);
    run_op(32'd32, 1'b0);
    run_op(32'd40, 1'b0);
    run_op(32'd8, 1'b0);
    run_op(32'h8000_0000, 1'b0);
    run_op(32'd33, 1'b0);
    run_op(32'd12, 1'b1);

    // Full sweep of valid counts
    for (int i = 0; i <= W; i++) run_op(i, 1'b0);

    // Randomized counts, mostly in range, some far out of range
    for (int i = 0; i < 30; i++) begin
      c = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, W + 8);
      run_op(c, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
